// File: rtl/vdp_port_ctrl.sv
// TMS9918-style CPU port controller: data/control port decode, R0-R7, VRAM A port, status latch.
// Optional read-ahead buffer and prefetch enabled by defining VDP_READ_AHEAD_EN.
module vdp_port_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_port,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        ready,
  output logic [13:0] vga_addr,
  output logic [7:0]  vga_din,
  output logic        vga_wr,
  output logic        vga_rd,
  input  logic [7:0]  vga_dout,
  input  logic        frame_tick,
  input  logic        sprite_collision,
  input  logic        too_many_sprites,
  input  logic [4:0]  sprite5,
  output logic [1:0]  mode,
  output logic        video_on,
  output logic        sprite_large,
  output logic        sprite_enlarged,
  output logic        vert_retrace_int,
  output logic [13:0] name_table_addr,
  output logic [13:0] color_table_addr,
  output logic [13:0] font_addr,
  output logic [13:0] sprite_attr_addr,
  output logic [13:0] sprite_pattern_table_addr,
  output logic [3:0]  text_color,
  output logic [3:0]  back_color,
  output logic        n_int
);

  typedef enum logic {ST_FIRST, ST_SECOND} ctrl_state_e;
  typedef enum logic [1:0] {PF_IDLE, PF_ISSUE, PF_CAPTURE} pf_state_e;

  ctrl_state_e ctrl_q, ctrl_d;
  pf_state_e   pf_q, pf_d;
  logic [7:0]  regs_q [8];
  logic [7:0]  regs_d [8];
  logic [13:0] addr_q, addr_d;
  logic [7:0]  latch_q, latch_d;
  logic [7:0]  cpu_dout_q, cpu_dout_d;
  logic        vga_wr_q, vga_wr_d;
  logic [13:0] vga_waddr_q, vga_waddr_d;
  logic [7:0]  vga_din_q, vga_din_d;
  logic        f_q, f_d, fs_q, fs_d, c_q, c_d;
  logic [4:0]  s5_q, s5_d;
  logic        n_int_q, n_int_d;
  logic        status_clr, fs_set;
  logic [7:0]  status;
`ifdef VDP_READ_AHEAD_EN
  logic [7:0]  rdbuf_q, rdbuf_d;
`endif

  assign status = {f_q, fs_q, c_q, s5_q};
  assign ready  = (pf_q == PF_IDLE);

  always_comb begin
    ctrl_d      = ctrl_q;
    pf_d        = pf_q;
    for (int unsigned i = 0; i < 8; i++) regs_d[i] = regs_q[i];
    addr_d      = addr_q;
    latch_d     = latch_q;
    cpu_dout_d  = cpu_dout_q;
    vga_wr_d    = 1'b0;
    vga_waddr_d = vga_waddr_q;
    vga_din_d   = vga_din_q;
    status_clr  = 1'b0;
`ifdef VDP_READ_AHEAD_EN
    rdbuf_d     = rdbuf_q;
`endif

    // Accesses are only accepted in PF_IDLE, so they never collide with the capture increment.
    case (pf_q)
      PF_ISSUE:   pf_d = PF_CAPTURE;
      PF_CAPTURE: begin
        pf_d   = PF_IDLE;
        addr_d = addr_q + 14'd1;
`ifdef VDP_READ_AHEAD_EN
        rdbuf_d = vga_dout;
`else
        cpu_dout_d = vga_dout;
`endif
      end
      default: ;
    endcase

    if (cpu_wr && ready) begin
      if (cpu_port) begin
        if (ctrl_q == ST_FIRST) begin
          latch_d = cpu_din;
          ctrl_d  = ST_SECOND;
        end else begin
          ctrl_d = ST_FIRST;
          if (cpu_din[7]) begin
            regs_d[cpu_din[2:0]] = latch_q;
          end else begin
            addr_d = {cpu_din[5:0], latch_q};
`ifdef VDP_READ_AHEAD_EN
            if (!cpu_din[6]) pf_d = PF_ISSUE;
`endif
          end
        end
      end else begin
        vga_wr_d    = 1'b1;
        vga_waddr_d = addr_q;
        vga_din_d   = cpu_din;
        addr_d      = addr_q + 14'd1;
        ctrl_d      = ST_FIRST;
`ifdef VDP_READ_AHEAD_EN
        rdbuf_d     = cpu_din;
`endif
      end
    end else if (cpu_rd && ready) begin
      ctrl_d = ST_FIRST;
      if (cpu_port) begin
        cpu_dout_d = status;
        status_clr = 1'b1;
      end else begin
`ifdef VDP_READ_AHEAD_EN
        cpu_dout_d = rdbuf_q;
`endif
        pf_d = PF_ISSUE;
      end
    end

    // Set events take priority over the clear from a status read.
    fs_set  = too_many_sprites && !fs_q;
    f_d     = frame_tick | (f_q & ~status_clr);
    c_d     = sprite_collision | (c_q & ~status_clr);
    fs_d    = fs_set | (fs_q & ~status_clr);
    s5_d    = fs_set ? sprite5 : s5_q;
    n_int_d = ~(f_q & regs_q[1][5]);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q      <= ST_FIRST;
      pf_q        <= PF_IDLE;
      for (int unsigned i = 0; i < 8; i++) regs_q[i] <= '0;
      addr_q      <= '0;
      latch_q     <= '0;
      cpu_dout_q  <= '0;
      vga_wr_q    <= 1'b0;
      vga_waddr_q <= '0;
      vga_din_q   <= '0;
      f_q         <= 1'b0;
      fs_q        <= 1'b0;
      c_q         <= 1'b0;
      s5_q        <= '0;
      n_int_q     <= 1'b1;
`ifdef VDP_READ_AHEAD_EN
      rdbuf_q     <= '0;
`endif
    end else begin
      ctrl_q      <= ctrl_d;
      pf_q        <= pf_d;
      for (int unsigned i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
      addr_q      <= addr_d;
      latch_q     <= latch_d;
      cpu_dout_q  <= cpu_dout_d;
      vga_wr_q    <= vga_wr_d;
      vga_waddr_q <= vga_waddr_d;
      vga_din_q   <= vga_din_d;
      f_q         <= f_d;
      fs_q        <= fs_d;
      c_q         <= c_d;
      s5_q        <= s5_d;
      n_int_q     <= n_int_d;
`ifdef VDP_READ_AHEAD_EN
      rdbuf_q     <= rdbuf_d;
`endif
    end
  end

  assign cpu_dout = cpu_dout_q;
  assign n_int    = n_int_q;
  assign vga_wr   = vga_wr_q;
  assign vga_rd   = (pf_q == PF_ISSUE);
  assign vga_din  = vga_din_q;
  assign vga_addr = vga_wr_q ? vga_waddr_q : addr_q;

  always_comb begin
    if (regs_q[1][4])      mode = 2'd0;
    else if (regs_q[0][1]) mode = 2'd2;
    else if (regs_q[1][3]) mode = 2'd3;
    else                   mode = 2'd1;
  end

  assign video_on         = regs_q[1][6];
  assign vert_retrace_int = regs_q[1][5];
  assign sprite_large     = regs_q[1][1];
  assign sprite_enlarged  = regs_q[1][0];

  assign name_table_addr           = {regs_q[2][3:0], 10'd0};
  assign sprite_attr_addr          = {regs_q[5][6:0], 7'd0};
  assign sprite_pattern_table_addr = {regs_q[6][2:0], 11'd0};
  assign color_table_addr = (mode == 2'd2) ? {regs_q[3][7], 13'd0} : {regs_q[3], 6'd0};
  assign font_addr        = (mode == 2'd2) ? {regs_q[4][2], 13'd0} : {regs_q[4][2:0], 11'd0};
  assign text_color = regs_q[7][7:4];
  assign back_color = regs_q[7][3:0];

  logic unused_reg_bits;
  assign unused_reg_bits = ^{regs_q[0][7:2], regs_q[0][0], regs_q[1][7], regs_q[1][2],
                             regs_q[2][7:4], regs_q[4][7:3], regs_q[5][7], regs_q[6][7:3]};

endmodule

// File: tb/tb_vdp_port_ctrl.sv
// Directed bench for vdp_port_ctrl: register decode table plus VRAM, read, interrupt and status sequences.
// Also covers the VDP_READ_AHEAD_EN build when that macro is defined.
module tb_vdp_port_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_port = 1'b0, cpu_wr = 1'b0, cpu_rd = 1'b0;
  logic [7:0]  cpu_din = '0;
  logic [7:0]  cpu_dout;
  logic        ready;
  logic [13:0] vga_addr;
  logic [7:0]  vga_din;
  logic        vga_wr, vga_rd;
  logic [7:0]  vga_dout = '0;
  logic        frame_tick = 1'b0, sprite_collision = 1'b0, too_many_sprites = 1'b0;
  logic [4:0]  sprite5 = '0;
  logic [1:0]  mode;
  logic        video_on, sprite_large, sprite_enlarged, vert_retrace_int;
  logic [13:0] name_table_addr, color_table_addr, font_addr, sprite_attr_addr, sprite_pattern_table_addr;
  logic [3:0]  text_color, back_color;
  logic        n_int;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  logic [7:0] vram [16384];

  vdp_port_ctrl dut (
    .clk(clk), .reset(reset), .cpu_port(cpu_port), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .ready(ready),
    .vga_addr(vga_addr), .vga_din(vga_din), .vga_wr(vga_wr), .vga_rd(vga_rd), .vga_dout(vga_dout),
    .frame_tick(frame_tick), .sprite_collision(sprite_collision),
    .too_many_sprites(too_many_sprites), .sprite5(sprite5),
    .mode(mode), .video_on(video_on), .sprite_large(sprite_large),
    .sprite_enlarged(sprite_enlarged), .vert_retrace_int(vert_retrace_int),
    .name_table_addr(name_table_addr), .color_table_addr(color_table_addr), .font_addr(font_addr),
    .sprite_attr_addr(sprite_attr_addr), .sprite_pattern_table_addr(sprite_pattern_table_addr),
    .text_color(text_color), .back_color(back_color), .n_int(n_int)
  );

  always #5 clk = ~clk;

  // Synchronous VRAM model: read data appears the cycle after vga_rd.
  always @(posedge clk) begin
    if (vga_wr) vram[vga_addr] <= vga_din;
    if (vga_rd) vga_dout <= vram[vga_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [2:0]  r;
    logic [7:0]  v;
    logic [1:0]  mode;
    logic [13:0] name, color, font, sattr, spat;
    logic [3:0]  text, back;
    logic [3:0]  flags;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic port, input logic [7:0] d);
    cpu_port = port;
    cpu_din  = d;
    cpu_wr   = 1'b1;
    tick();
    cpu_wr   = 1'b0;
  endtask

  task automatic cpu_read(input logic port);
    cpu_port = port;
    cpu_rd   = 1'b1;
    tick();
    cpu_rd   = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 8 && !ready; i++) tick();
    check(name, ready, 1'b1);
  endtask

  task automatic data_read(input logic [7:0] exp, input string name);
    cpu_read(1'b0);
`ifdef VDP_READ_AHEAD_EN
    check({name, "_dout"}, cpu_dout, exp);
    check({name, "_rdy1"}, ready, 1'b0);
    tick();
    check({name, "_rdy2"}, ready, 1'b0);
    tick();
    check({name, "_rdy3"}, ready, 1'b1);
`else
    check({name, "_rdy1"}, ready, 1'b0);
    tick();
    check({name, "_rdy2"}, ready, 1'b0);
    tick();
    check({name, "_dout"}, cpu_dout, exp);
    check({name, "_rdy3"}, ready, 1'b1);
`endif
  endtask

  function automatic vec_t mk(input logic [2:0] r, input logic [7:0] v, input logic [1:0] m,
                              input logic [13:0] nm, input logic [13:0] co, input logic [13:0] fo,
                              input logic [13:0] sa, input logic [13:0] sp,
                              input logic [3:0] tc, input logic [3:0] bc, input logic [3:0] fl);
    vec_t x;
    x.r = r; x.v = v; x.mode = m; x.name = nm; x.color = co; x.font = fo;
    x.sattr = sa; x.spat = sp; x.text = tc; x.back = bc; x.flags = fl;
    return x;
  endfunction

  initial begin
    // Cumulative register writes; flags = {video_on, IE, sprite_large, sprite_enlarged}.
    vecs[0]  = mk(3'd7, 8'h00, 2'd1, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 4'h0, 4'h0, 4'h0);
    vecs[1]  = mk(3'd7, 8'hF4, 2'd1, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 4'hF, 4'h4, 4'h0);
    vecs[2]  = mk(3'd0, 8'h02, 2'd2, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 4'hF, 4'h4, 4'h0);
    vecs[3]  = mk(3'd2, 8'h06, 2'd2, 14'h1800, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 4'hF, 4'h4, 4'h0);
    vecs[4]  = mk(3'd3, 8'hFF, 2'd2, 14'h1800, 14'h2000, 14'h0000, 14'h0000, 14'h0000, 4'hF, 4'h4, 4'h0);
    vecs[5]  = mk(3'd4, 8'h03, 2'd2, 14'h1800, 14'h2000, 14'h0000, 14'h0000, 14'h0000, 4'hF, 4'h4, 4'h0);
    vecs[6]  = mk(3'd0, 8'h00, 2'd1, 14'h1800, 14'h3FC0, 14'h1800, 14'h0000, 14'h0000, 4'hF, 4'h4, 4'h0);
    vecs[7]  = mk(3'd1, 8'h08, 2'd3, 14'h1800, 14'h3FC0, 14'h1800, 14'h0000, 14'h0000, 4'hF, 4'h4, 4'h0);
    vecs[8]  = mk(3'd1, 8'h53, 2'd0, 14'h1800, 14'h3FC0, 14'h1800, 14'h0000, 14'h0000, 4'hF, 4'h4, 4'hB);
    vecs[9]  = mk(3'd5, 8'hFF, 2'd0, 14'h1800, 14'h3FC0, 14'h1800, 14'h3F80, 14'h0000, 4'hF, 4'h4, 4'hB);
    vecs[10] = mk(3'd6, 8'h07, 2'd0, 14'h1800, 14'h3FC0, 14'h1800, 14'h3F80, 14'h3800, 4'hF, 4'h4, 4'hB);
    vecs[11] = mk(3'd1, 8'h20, 2'd1, 14'h1800, 14'h3FC0, 14'h1800, 14'h3F80, 14'h3800, 4'hF, 4'h4, 4'h4);

    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;

    check("rst_dout", cpu_dout, 8'h00);
    check("rst_ready", ready, 1'b1);
    check("rst_n_int", n_int, 1'b1);
    check("rst_vga_strobes", {vga_wr, vga_rd}, 2'b00);
    check("rst_decode",
          {mode, video_on, name_table_addr, color_table_addr, font_addr, sprite_attr_addr,
           sprite_pattern_table_addr, text_color, back_color},
          {2'd1, 1'b0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 4'h0, 4'h0});

    for (int i = 0; i < 12; i++) begin
      cpu_write(1'b1, vecs[i].v);
      cpu_write(1'b1, {5'b10000, vecs[i].r});
      check($sformatf("regvec%0d", i),
            {mode, name_table_addr, color_table_addr, font_addr, sprite_attr_addr,
             sprite_pattern_table_addr, text_color, back_color,
             video_on, vert_retrace_int, sprite_large, sprite_enlarged},
            {vecs[i].mode, vecs[i].name, vecs[i].color, vecs[i].font, vecs[i].sattr,
             vecs[i].spat, vecs[i].text, vecs[i].back, vecs[i].flags});
    end

    // VRAM writes across the 14-bit address wrap.
    cpu_write(1'b1, 8'hFF);
    cpu_write(1'b1, 8'h7F);
    cpu_write(1'b0, 8'hAA);
    check("wr_strobe", {vga_wr, vga_addr, vga_din}, {1'b1, 14'h3FFF, 8'hAA});
    cpu_write(1'b0, 8'h55);
    check("wr_wrap_addr", vga_addr, 14'h0000);
    cpu_write(1'b0, 8'h77);
    tick();
    tick();
    check("vram_3fff", vram[14'h3FFF], 8'hAA);
    check("vram_0000", vram[14'h0000], 8'h55);
    check("vram_0001", vram[14'h0001], 8'h77);
    check("wr_strobe_done", vga_wr, 1'b0);

    cpu_write(1'b1, 8'h00);
    cpu_write(1'b1, 8'h50);
    cpu_write(1'b0, 8'h11);
    cpu_write(1'b0, 8'h22);
    tick();

    // Read address set; prefetch only in the read-ahead build.
    cpu_write(1'b1, 8'h00);
    cpu_write(1'b1, 8'h10);
`ifdef VDP_READ_AHEAD_EN
    check("setrd_prefetch_busy", ready, 1'b0);
    wait_ready("setrd_prefetch_done");
`else
    check("setrd_no_prefetch", ready, 1'b1);
`endif
    data_read(8'h11, "read0");
    data_read(8'h22, "read1");

    // Interrupt flag with IE already set by the last table vector.
    check("irq_idle", n_int, 1'b1);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    check("irq_lag", n_int, 1'b1);
    tick();
    check("irq_assert", n_int, 1'b0);
    cpu_read(1'b1);
    check("status_f", cpu_dout, 8'h80);
    tick();
    check("irq_release", n_int, 1'b1);

    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    tick();
    frame_tick = 1'b1;
    cpu_read(1'b1);
    frame_tick = 1'b0;
    check("status_f_coincident", cpu_dout, 8'h80);
    tick();
    check("irq_held", n_int, 1'b0);
    cpu_read(1'b1);
    check("status_f_kept", cpu_dout, 8'h80);
    tick();
    check("irq_release2", n_int, 1'b1);

    // Fifth-sprite latch: S5 frozen once 5S is set.
    too_many_sprites = 1'b1;
    sprite5 = 5'd5;
    tick();
    sprite5 = 5'd9;
    tick();
    too_many_sprites = 1'b0;
    cpu_read(1'b1);
    check("status_5s", cpu_dout, 8'h45);
    sprite_collision = 1'b1;
    tick();
    sprite_collision = 1'b0;
    cpu_read(1'b1);
    check("status_c", cpu_dout, 8'h25);
    cpu_read(1'b1);
    check("status_cleared", cpu_dout, 8'h05);

    // Reset during a prefetch aborts it.
    cpu_read(1'b0);
    check("abort_busy", ready, 1'b0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort_ready", ready, 1'b1);
    check("abort_dout", cpu_dout, 8'h00);
    check("abort_vga_rd", vga_rd, 1'b0);
    tick();
    check("abort_still_idle", {ready, vga_rd}, 2'b10);
`ifdef VDP_READ_AHEAD_EN
    data_read(8'h00, "read_after_reset");
`else
    data_read(8'h55, "read_after_reset");
`endif
    wait_ready("final_ready");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vdp_port_ctrl.md
# vdp_port_ctrl

TMS9918-style CPU port controller that sequences and configures the MSX video block. Decodes CPU accesses to the data port (0x98) and control port (0x99), holds VDP registers R0–R7, drives the CPU-side VRAM port (address auto-increment, read-ahead buffer) and latches the status register from the video block's live sprite/frame signals. Sits between the Z80 I/O decode and the video block, on the CPU clock.

## Interface
- no parameters; all widths fixed by the TMS9918 register map
- `clk` in 1: CPU clock; also clocks the VRAM A port
- `reset` in 1: synchronous, active-low
- `cpu_port` in 1: 0 = data port, 1 = control port
- `cpu_wr`, `cpu_rd` in 1: one-cycle access strobes, mutually exclusive; ignored while `ready`=0
- `cpu_din` in 8: write data
- `cpu_dout` out 8: read data, registered
- `ready` out 1: controller can accept an access
- `vga_addr` out 14, `vga_din` out 8, `vga_wr` out 1, `vga_rd` out 1: VRAM A port; `vga_dout` in 8, valid the cycle after `vga_rd`
- `frame_tick` in 1: one-cycle pulse at start of vertical retrace
- `sprite_collision`, `too_many_sprites` in 1; `sprite5` in 5: live sprite status from the video block
- `mode` out 2; `video_on`, `sprite_large`, `sprite_enlarged`, `vert_retrace_int` out 1
- `name_table_addr`, `color_table_addr`, `font_addr`, `sprite_attr_addr`, `sprite_pattern_table_addr` out 14
- `text_color`, `back_color` out 4
- `n_int` out 1: active-low CPU interrupt = !(F & IE)

## Operation
- Control-port FSM with states FIRST and SECOND. Write in FIRST: `latch` <= cpu_din, go SECOND. Write in SECOND, go FIRST:
  - din[7]=1: R[din[2:0]] <= latch.
  - din[7:6]=00: addr <= {din[5:0], latch}; start prefetch.
  - din[7:6]=01: addr <= {din[5:0], latch}; no prefetch.
- Data-port write: vga_wr=1, vga_addr=addr, vga_din=cpu_din for one cycle; `rdbuf` <= cpu_din; addr++; FSM to FIRST.
- Data-port read: cpu_dout <= rdbuf; start prefetch; FSM to FIRST.
- Prefetch sub-FSM IDLE → ISSUE (vga_rd=1, vga_addr=addr) → CAPTURE (rdbuf <= vga_dout, addr++) → IDLE. `ready`=0 in ISSUE and CAPTURE.
- addr is 14 bits; 0x3FFF + 1 wraps to 0x0000.
- Register decode: M1=R1[4], M2=R1[3], M3=R0[1]. mode = 0 if M1, else 2 if M3, else 3 if M2, else 1. video_on=R1[6]; vert_retrace_int (IE)=R1[5]; sprite_large=R1[1]; sprite_enlarged=R1[0].
- Table addresses: name = R2[3:0]<<10; sprite_attr = R5[6:0]<<7; sprite_pattern = R6[2:0]<<11. In mode 2: color = R3[7]<<13, font = R4[2]<<13. Otherwise: color = R3<<6, font = R4[2:0]<<11. text_color=R7[7:4]; back_color=R7[3:0].
- Status byte = {F, 5S, C, S5[4:0]}. Updates:
  - frame_tick sets F.
  - sprite_collision high sets C (sticky).
  - too_many_sprites high while 5S=0 sets 5S and loads S5 <= sprite5.
  - S5 otherwise holds its last value.
- Control-port read: cpu_dout <= status (pre-edge value); clears F, 5S, C; FSM to FIRST. A set event in the same cycle as the clear wins.

## Timing
- Reset (reset=0 at a clk edge): R0–R7=0, addr=0, latch=0, rdbuf=0, FSMs FIRST/IDLE, status=0, cpu_dout=0, vga_wr=vga_rd=0, ready=1, n_int=1. Decoded outputs after reset: mode=1, all table addresses 0, colours 0, video_on=0.
- Reset asserted mid-prefetch aborts it; rdbuf is not updated.
- cpu_dout is valid on the cycle after the accepted cpu_rd edge.
- Register writes take effect on outputs one cycle after the second control write.
- A prefetch occupies exactly 2 cycles; the next access is accepted at the earliest on the 3rd cycle after the triggering access.
- n_int changes one cycle after F or IE changes.

## Configuration
- `VDP_READ_AHEAD_EN` defined: data-port reads behave as described (buffered, prefetch after the read).
- Not defined: no read-ahead buffer and no prefetch after address set. A data-port read drops `ready` for 2 cycles, issues vga_rd at addr, and delivers cpu_dout = vga_dout 2 cycles after the cpu_rd edge, then increments addr. Data-port writes do not load a buffer.

## Test plan
- Reset, then control writes 0x00, 0x87 → R7=0x00; control writes 0xF4, 0x87 → text_color=0xF, back_color=0x4.
- Control writes 0x02,0x80 then 0x06,0x82 (mode 2; R2=0x06) → mode=2, name_table_addr=0x1800; writing R3=0xFF, R4=0x03 → color_table_addr=0x2000, font_addr=0x0000.
- Set write address 0x3FFF (0xFF, 0x7F); data writes 0xAA, 0x55 → VRAM[0x3FFF]=0xAA, VRAM[0x0000]=0x55, addr=0x0001.
- With `VDP_READ_AHEAD_EN`: set read address 0x1000 (0x00, 0x10) with VRAM[0x1000]=0x11, VRAM[0x1001]=0x22; two data reads → 0x11 then 0x22; `ready` low 2 cycles after each.
- R1=0x20 (IE); pulse frame_tick → n_int=0 next cycle. Status read → bit7=1, n_int=1. Repeat with frame_tick coincident with the read → F stays 1.
- too_many_sprites=1 with sprite5=5 → status=0x45. sprite5 changed to 9 before the status read → still 0x45. Status read clears 5S and C.
